// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: walks the enabled monitor channels, averages 2^shift
// conversions per channel and strobes one 12-bit result per channel downstream.
module adc_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned MIN_STROBE_GAP = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [4:0]  adc_mux_sel,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] adc_result,
  output logic [4:0]  adc_channel,
  output logic        adc_strb
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(MIN_STROBE_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_STROBE_GAP);
  localparam logic [GW-1:0] GAP_FIRE = GW'(MIN_STROBE_GAP - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [15:0] ADR_EN0    = 16'd0;
  localparam logic [15:0] ADR_EN1    = 16'd1;
  localparam logic [15:0] ADR_SHIFT  = 16'd2;
  localparam logic [15:0] ADR_CTRL   = 16'd3;
  localparam logic [15:0] ADR_COUNT  = 16'd4;
  localparam logic [15:0] ADR_STATUS = 16'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONV_START,
    ST_CONV_WAIT,
    ST_EMIT
  } state_t;

  state_t state, state_d;

  logic        trans;
  logic [15:0] rd_data;
  logic [31:0] chan_en;
  logic [2:0]  avg_shift;
  logic        run;
  logic [15:0] scan_count;
  logic        timeout_flag;

  logic [4:0]    ptr;
  logic [4:0]    cur_chan;
  logic [2:0]    cur_shift;
  logic [16:0]   acc;
  logic [4:0]    sample_cnt;
  logic [7:0]    settle_cnt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gap_cnt;

  logic [4:0] next_chan;
  logic [4:0] cand;
  logic       found;
  logic       higher_en;
  logic       last_sample;
  logic       gap_ok;
  logic       tmr_last;
  logic       sample_take;
  logic       timeout_evt;
  logic       emit_fire;

  // ---------------- Wishbone register file ----------------
  assign trans = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_EN0:    rd_data = chan_en[15:0];
      ADR_EN1:    rd_data = chan_en[31:16];
      ADR_SHIFT:  rd_data = {13'b0, avg_shift};
      ADR_CTRL:   rd_data = {15'b0, run};
      ADR_COUNT:  rd_data = scan_count;
      ADR_STATUS: rd_data = {15'b0, timeout_flag};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      chan_en      <= '0;
      avg_shift    <= '0;
      run          <= 1'b0;
      scan_count   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wb_ack_o <= trans;
      if (trans)
        wb_dat_o <= rd_data;
      if (trans && wb_we_i) begin
        case (wb_adr_i)
          ADR_EN0:    chan_en[15:0]  <= wb_dat_i;
          ADR_EN1:    chan_en[31:16] <= wb_dat_i;
          ADR_SHIFT:  avg_shift      <= (wb_dat_i > 16'd4) ? 3'd4 : wb_dat_i[2:0];
          ADR_CTRL:   run            <= wb_dat_i[0];
          ADR_STATUS: if (wb_dat_i[0]) timeout_flag <= 1'b0;
          default: ;
        endcase
      end
      // A timeout landing in the same cycle as a clear write stays visible.
      if (timeout_evt)
        timeout_flag <= 1'b1;
      if (emit_fire && !higher_en)
        scan_count <= scan_count + 16'd1;
    end
  end

  // ---------------- Channel selection helpers ----------------
  always_comb begin
    next_chan = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= 32; i++) begin
      cand = ptr + 5'(i);
      if (!found && chan_en[cand]) begin
        found     = 1'b1;
        next_chan = cand;
      end
    end
  end

  // Anything above bit 0 after the shift means a higher channel is enabled.
  assign higher_en   = (chan_en >> cur_chan) > 32'd1;
  assign last_sample = (sample_cnt + 5'd1) == (5'd1 << cur_shift);
  assign gap_ok      = gap_cnt >= GAP_FIRE;
  assign tmr_last    = tmr == TMR_LAST;

  // ---------------- FSM ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d     = state;
    adc_start   = 1'b0;
    sample_take = 1'b0;
    timeout_evt = 1'b0;
    emit_fire   = 1'b0;
    unique case (state)
      ST_IDLE:   if (run && found) state_d = ST_SELECT;
      ST_SELECT: state_d = (run && found) ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: if (settle_cnt == '0) state_d = ST_CONV_START;
      ST_CONV_START: begin
        adc_start = 1'b1;
        state_d   = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        if (adc_done) begin
          sample_take = run;
          if (!run)
            state_d = ST_IDLE;
          else if (last_sample)
            state_d = ST_EMIT;
          else
            state_d = ST_CONV_START;
        end else if (tmr_last) begin
          timeout_evt = 1'b1;
          state_d     = run ? ST_SELECT : ST_IDLE;
        end
      end
      ST_EMIT: if (gap_ok) begin
        emit_fire = 1'b1;
        state_d   = ST_SELECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr         <= 5'd31;
      cur_chan    <= '0;
      cur_shift   <= '0;
      acc         <= '0;
      sample_cnt  <= '0;
      settle_cnt  <= '0;
      tmr         <= '0;
      gap_cnt     <= '0;
      adc_mux_sel <= '0;
      adc_result  <= '0;
      adc_channel <= '0;
      adc_strb    <= 1'b0;
    end else begin
      adc_strb <= emit_fire;
      if (emit_fire)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + 1'b1;

      case (state)
        ST_SELECT: if (state_d == ST_SETTLE) begin
          cur_chan    <= next_chan;
          adc_mux_sel <= next_chan;
          cur_shift   <= avg_shift;
          acc         <= '0;
          sample_cnt  <= '0;
          settle_cnt  <= 8'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE:     if (settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
        ST_CONV_START: tmr <= '0;
        ST_CONV_WAIT: begin
          tmr <= tmr + 1'b1;
          if (sample_take) begin
            acc        <= acc + {5'b0, adc_data};
            sample_cnt <= sample_cnt + 5'd1;
          end
          // A timed-out channel is skipped; with run cleared the pointer stays put.
          if (timeout_evt && run)
            ptr <= cur_chan;
        end
        ST_EMIT: if (emit_fire) begin
          adc_result  <= 12'(acc >> cur_shift);
          adc_channel <= cur_chan;
          ptr         <= cur_chan;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Upstream stage of the level checker: owns the ADC mux and conversion handshake, cycles through the enabled monitor channels, and averages 2^shift conversions per channel.
- Delivers one averaged 12-bit result per channel on adc_result/adc_channel/adc_strb, the exact interface the level checker samples.
- Configured over the same 16-bit Wishbone slave bus as the rest of the monitor.

Parameters:
SETTLE_CYCLES, 8, clocks to wait after changing adc_mux_sel before the first conversion (1..255)
MIN_STROBE_GAP, 16, minimum clocks between adc_strb pulses, so the downstream checker (4 RAM compares plus bus stalls) never misses one
TIMEOUT_CYCLES, 1023, clocks to wait for adc_done before abandoning a conversion

Ports:
wb_clk_i  in  1  the single clock
wb_rst_i  in  1  reset; one clock, synchronous, active-high
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write enable
wb_adr_i  in  16  register address
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, valid with wb_ack_o
wb_ack_o  out  1  one-cycle acknowledge
adc_mux_sel  out  5  analogue mux channel select
adc_start  out  1  one-cycle conversion request
adc_done  in  1  one-cycle conversion complete, qualifies adc_data
adc_data  in  12  raw conversion value
adc_result  out  12  averaged result, held until the next strobe
adc_channel  out  5  channel of adc_result
adc_strb  out  1  one-cycle result-valid pulse

Behaviour:
Wishbone:
- trans = cyc & stb & ~ack.
- ack asserts one cycle after trans; no wait states.
- wb_dat_o is registered on trans.
- Unmapped addresses read 0 and ignore writes.
Registers:
- 0 CHAN_EN_0: mask, channels 15:0.
- 1 CHAN_EN_1: mask, channels 31:16.
- 2 AVG_SHIFT: bits [2:0]; a write above 4 stores 4.
- 3 CONTROL: bit0 run.
- 4 SCAN_COUNT: read-only, 16-bit, wraps.
- 5 STATUS: bit0 timeout sticky; writing 1 clears it.
Reset:
- All registers 0, state IDLE.
- adc_start, adc_strb, adc_mux_sel, adc_result and adc_channel are 0.
- Channel pointer is 31, so the first scan starts at channel 0.
FSM:
- IDLE: if run=1 and the mask is non-zero, go to SELECT. adc_done is ignored in IDLE.
- SELECT (1 clk):
  - Pick the lowest enabled channel above the pointer, wrapping mod 32.
  - Drive adc_mux_sel, clear the accumulator (17 bits) and the sample count, load the settle counter, go to SETTLE.
  - If run=0 or the mask is 0, go to IDLE.
- SETTLE: count SETTLE_CYCLES clocks, then go to CONVERT.
- CONVERT:
  - Pulse adc_start for 1 clk, then wait for adc_done.
  - On adc_done: acc += adc_data, count++.
  - If count == 2^shift, go to EMIT; otherwise pulse adc_start again with no re-settle.
  - Shift is latched at SELECT, so mid-channel writes do not affect the current channel.
- Timeout: if TIMEOUT_CYCLES elapse without adc_done, set the timeout bit, advance the pointer and return to SELECT with no strobe.
- EMIT:
  - Wait until the gap counter (clocks since the last strobe, saturating) is at least MIN_STROBE_GAP.
  - Then assign adc_result = acc >> shift (truncating) and adc_channel = current channel, and pulse adc_strb for 1 clk.
  - The pointer becomes the current channel.
  - SCAN_COUNT increments if no enabled channel lies above the current one. A single-channel mask therefore increments on every emit.
  - Then go to SELECT.
Boundary cases:
- Mask change mid-channel: the current channel completes; the new mask applies at the next SELECT.
- Run cleared mid-CONVERT: finish the outstanding conversion (adc_done or timeout), discard the result, no strobe, go to IDLE. The pointer is kept.
- wb_rst_i mid-operation: immediate return to reset values; adc_start drops the same cycle the reset is sampled.
- adc_done in the same cycle as adc_start: not accepted, because adc_done is counted only in the wait phase.
- Accumulator: 16 x 4095 = 65520 fits in 17 bits, so it cannot overflow.

Test Plan:
- Mask 0x0000_0005, shift 0, run=1; ADC model returns 0x123 on channel 0 and 0xABC on channel 2 after 5 clks -> strobes alternate ch0/0x123 and ch2/0xABC; each adc_start comes 8 clks after the mux change; strobe spacing is at least 16; SCAN_COUNT increments after each ch2 strobe.
- Shift 2, single channel 7; ADC returns 100, 101, 102, 104 -> one strobe, ch7, result 101; exactly 4 adc_start pulses with no settle between them.
- Shift 4; ADC always returns 0xFFF -> result 0xFFF, with no overflow.
- Write 7 to AVG_SHIFT -> reads back 4.
- ADC model never asserts adc_done -> after 1023 clks STATUS bit0 = 1, there is no strobe, and the sequencer moves to the next channel; writing 1 to STATUS clears the bit.
- Clear run during a conversion, then assert wb_rst_i mid-SETTLE -> no strobe in either case; after the reset, all outputs and registers read 0 and the next scan starts at the lowest enabled channel.
